main_memory: RTL and testbench

MAIN_MEMORY -- requirements
Module: main_memory

---
 rtl/main_memory_pkg.sv | 11 +
 rtl/main_memory_if.sv | 15 +
 rtl/main_memory_mem_array.sv | 17 +
 rtl/main_memory.sv | 60 ++++++
 tb/tb_main_memory.sv | 197 +++++++++++++++++++
 5 files changed

// File: rtl/main_memory_pkg.sv
// main_memory_pkg: FSM state encoding and read/write encoding shared by the memory and the cache.
package main_memory_pkg;
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;
    localparam logic RW_READ  = 1'b1;
    localparam logic RW_WRITE = 1'b0;
    localparam int   CNT_W    = 4;
endpackage

// File: rtl/main_memory_if.sv
// main_memory_if: request/response bundle between the cache (master) and main memory (slave).
interface main_memory_if #(
    parameter int d_width = 8,
    parameter int a_width = 8
);
    logic               ce_in;
    logic               rw_in;
    logic [a_width-1:0] addr_in;
    logic [d_width-1:0] data_in;
    logic [d_width-1:0] data_out;
    logic               odv;
    logic               busy;
    modport master (output ce_in, rw_in, addr_in, data_in, input data_out, odv, busy);
    modport slave  (input ce_in, rw_in, addr_in, data_in, output data_out, odv, busy);
endinterface

// File: rtl/main_memory_mem_array.sv
// mem_array: single-port storage with clocked write and combinational read; contents survive reset.
module mem_array #(
    parameter int d_width = 8,
    parameter int a_width = 8
) (
    input  logic               clk,
    input  logic               i_we,
    input  logic [a_width-1:0] i_addr,
    input  logic [d_width-1:0] i_wdata,
    output logic [d_width-1:0] o_rdata
);
    logic [d_width-1:0] r_mem [2**a_width];
    always_ff @(posedge clk) begin
        if (i_we) r_mem[i_addr] <= i_wdata;
    end
    assign o_rdata = r_mem[i_addr];
endmodule

// File: rtl/main_memory.sv
// main_memory: fixed-latency memory model; one request in flight, completion signalled by a one-cycle odv.
module main_memory
    import main_memory_pkg::*;
#(
    parameter int d_width = 8,
    parameter int a_width = 8,
    parameter int latency = 6
) (
    input  logic         clk,
    input  logic         clr,
    main_memory_if.slave bus
);
    state_t             r_state, w_next;
    logic [CNT_W-1:0]   r_cnt, w_cnt_next;
    logic               r_rw;
    logic [a_width-1:0] r_addr;
    logic [d_width-1:0] r_wdata, r_data_out, w_rdata;
    logic               w_accept, w_fin, w_we;

    mem_array #(.d_width(d_width), .a_width(a_width)) u_array (
        .clk    (clk),
        .i_we   (w_we),
        .i_addr (r_addr),
        .i_wdata(r_wdata),
        .o_rdata(w_rdata)
    );

    // DONE accepts like IDLE so back-to-back requests never pass through IDLE
    always_comb begin
        w_accept   = bus.ce_in && (r_state != BUSY);
        w_fin      = (r_state == BUSY) && (r_cnt == CNT_W'(1));
        w_we       = w_fin && (r_rw == RW_WRITE);
        w_next     = w_accept ? BUSY : (r_state == BUSY) ? (w_fin ? DONE : BUSY) : IDLE;
        w_cnt_next = w_accept ? CNT_W'(latency - 1) : (r_state == BUSY) ? r_cnt - CNT_W'(1) : r_cnt;
    end

    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            r_state    <= IDLE;
            r_cnt      <= '0;
            r_rw       <= 1'b0;
            r_addr     <= '0;
            r_wdata    <= '0;
            r_data_out <= '0;
        end else begin
            r_state <= w_next;
            r_cnt   <= w_cnt_next;
            if (w_accept) begin
                r_rw    <= bus.rw_in;
                r_addr  <= bus.addr_in;
                r_wdata <= bus.data_in;
            end
            if (w_fin && r_rw == RW_READ) r_data_out <= w_rdata;
        end
    end

    assign bus.odv      = (r_state == DONE);
    assign bus.busy     = (r_state == BUSY);
    assign bus.data_out = r_data_out;
endmodule

// File: tb/tb_main_memory.sv
// tb_main_memory: vector table, random transactions against an array model, and timing corner cases.
module tb_main_memory;
    typedef struct {
        logic       rw;
        logic [7:0] addr;
        logic [7:0] data;
        logic [7:0] exp;
    } vec_t;

    logic       clk = 1'b0;
    logic       clr = 1'b0;
    int         n_cmp = 0;
    int         n_bad = 0;
    logic [7:0] mem_m [256];
    logic [7:0] exp_dout = 8'h00;
    vec_t       vec [9];

    main_memory_if #(.d_width(8), .a_width(8)) bus ();
    main_memory_if #(.d_width(8), .a_width(8)) bus2 ();

    main_memory #(.d_width(8), .a_width(8), .latency(6)) dut  (.clk(clk), .clr(clr), .bus(bus));
    main_memory #(.d_width(8), .a_width(8), .latency(2)) dut2 (.clk(clk), .clr(clr), .bus(bus2));

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic start(input logic rw, input logic [7:0] a, input logic [7:0] d);
        bus.ce_in   = 1'b1;
        bus.rw_in   = rw;
        bus.addr_in = a;
        bus.data_in = d;
    endtask

    // request fields are scrambled while busy; they must not matter
    task automatic finish(output int edges, output logic busy_ok);
        @(negedge clk);
        bus.ce_in = 1'b0;
        edges     = 0;
        busy_ok   = 1'b1;
        for (int i = 0; i < 20; i++) begin
            if (bus.odv) begin
                edges = i + 1;
                break;
            end
            if (!bus.busy) busy_ok = 1'b0;
            bus.rw_in   = 1'($urandom);
            bus.addr_in = 8'($urandom);
            bus.data_in = 8'($urandom);
            @(negedge clk);
        end
    endtask

    task automatic xact(input string name, input logic rw, input logic [7:0] a,
                        input logic [7:0] d, input logic [7:0] exp);
        int   e;
        logic b;
        @(negedge clk);
        start(rw, a, d);
        finish(e, b);
        chk({name, "_latency"}, e, 6);
        chk({name, "_busy_held"}, b, 1);
        chk({name, "_busy_in_done"}, bus.busy, 0);
        chk({name, "_data_out"}, bus.data_out, exp);
    endtask

    task automatic model_xact(input logic rw, input logic [7:0] a, input logic [7:0] d);
        xact("rand", rw, a, d, rw ? mem_m[a] : exp_dout);
        if (rw) exp_dout = mem_m[a];
        else mem_m[a] = d;
    endtask

    task automatic chk_idle(input string name);
        chk({name, "_odv"}, bus.odv, 0);
        chk({name, "_busy"}, bus.busy, 0);
        chk({name, "_data_out"}, bus.data_out, 0);
    endtask

    initial begin
        int         e1, e2, n_odv;
        logic       b1, b2;
        logic [7:0] ra;
        vec[0] = '{1'b0, 8'h3C, 8'hA5, 8'h00};
        vec[1] = '{1'b1, 8'h3C, 8'h00, 8'hA5};
        vec[2] = '{1'b0, 8'hFF, 8'h11, 8'hA5};
        vec[3] = '{1'b1, 8'hFF, 8'h00, 8'h11};
        vec[4] = '{1'b0, 8'h00, 8'h22, 8'h11};
        vec[5] = '{1'b1, 8'h00, 8'h00, 8'h22};
        vec[6] = '{1'b0, 8'h3C, 8'h5C, 8'h22};
        vec[7] = '{1'b1, 8'hFF, 8'h00, 8'h11};
        vec[8] = '{1'b1, 8'h3C, 8'h00, 8'h5C};
        bus.ce_in = 1'b0;  bus.rw_in = 1'b0;  bus.addr_in = 8'h00;  bus.data_in = 8'h00;
        bus2.ce_in = 1'b0; bus2.rw_in = 1'b0; bus2.addr_in = 8'h00; bus2.data_in = 8'h00;

        clr = 1'b1;
        repeat (2) begin
            @(negedge clk);
            chk_idle("reset_active");
        end
        clr = 1'b0;
        repeat (2) begin
            @(negedge clk);
            chk_idle("reset_released");
        end

        for (int i = 0; i < 9; i++) begin
            xact("vec", vec[i].rw, vec[i].addr, vec[i].data, vec[i].exp);
            if (vec[i].rw) exp_dout = mem_m[vec[i].addr];
            else mem_m[vec[i].addr] = vec[i].data;
        end

        for (int a = 224; a < 256; a++) model_xact(1'b0, 8'(a), 8'($urandom));
        for (int i = 0; i < 40; i++) begin
            ra = 8'(224 + $urandom_range(0, 31));
            model_xact(1'($urandom), ra, 8'($urandom));
        end

        @(negedge clk);
        start(1'b0, 8'h20, 8'h9C);
        finish(e1, b1);
        start(1'b1, 8'h20, 8'h00);
        finish(e2, b2);
        chk("b2b_first_latency", e1, 6);
        chk("b2b_second_latency", e2, 6);
        chk("b2b_busy_held", b2, 1);
        chk("b2b_data_out", bus.data_out, 8'h9C);
        mem_m[8'h20] = 8'h9C;
        exp_dout     = 8'h9C;

        model_xact(1'b0, 8'h10, 8'h33);
        @(negedge clk);
        start(1'b1, 8'h10, 8'h00);
        n_odv = 0;
        e1    = 0;
        for (int i = 0; i < 14; i++) begin
            @(negedge clk);
            bus.ce_in   = (i == 1 || i == 3);
            bus.rw_in   = 1'b0;
            bus.addr_in = 8'h10;
            bus.data_in = 8'hFF;
            if (bus.odv) begin
                n_odv++;
                e1 = i + 1;
            end
        end
        chk("ignore_odv_count", n_odv, 1);
        chk("ignore_latency", e1, 6);
        chk("ignore_data_out", bus.data_out, 8'h33);
        exp_dout = 8'h33;
        model_xact(1'b1, 8'h10, 8'h00);

        model_xact(1'b0, 8'h01, 8'h77);
        @(negedge clk);
        start(1'b0, 8'h01, 8'h55);
        @(negedge clk);
        bus.ce_in = 1'b0;
        repeat (2) @(negedge clk);
        clr = 1'b1;
        #1;
        chk_idle("abort_clr");
        @(negedge clk);
        clr = 1'b0;
        start(1'b1, 8'h01, 8'h00);
        finish(e1, b1);
        chk("abort_first_odv_latency", e1, 6);
        chk("abort_read_old", bus.data_out, 8'h77);

        @(negedge clk);
        bus2.ce_in = 1'b1; bus2.rw_in = 1'b0; bus2.addr_in = 8'hFF; bus2.data_in = 8'h5A;
        @(negedge clk);
        bus2.ce_in = 1'b0;
        chk("lat2_wr_odv_early", bus2.odv, 0);
        chk("lat2_wr_busy", bus2.busy, 1);
        @(negedge clk);
        chk("lat2_wr_odv", bus2.odv, 1);
        chk("lat2_wr_data_out_held", bus2.data_out, 8'h00);
        @(negedge clk);
        bus2.ce_in = 1'b1; bus2.rw_in = 1'b1; bus2.addr_in = 8'hFF; bus2.data_in = 8'h00;
        @(negedge clk);
        bus2.ce_in = 1'b0;
        chk("lat2_rd_odv_early", bus2.odv, 0);
        @(negedge clk);
        chk("lat2_rd_odv", bus2.odv, 1);
        chk("lat2_rd_data_out", bus2.data_out, 8'h5A);
        @(negedge clk);
        chk("lat2_odv_single", bus2.odv, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
